// File: rtl/lab3_cpu_ocimem_monitor.sv
// Debug monitor RAM and JTAG-side monitor registers, with an optional CPU Avalon-MM port.
// Define LAB3_OCIMEM_CPU_PORT_EN to compile in the CPU port and its read state.
module lab3_cpu_ocimem_monitor #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_writedata,
   output logic [31:0]       cpu_readdata,
   output logic              cpu_waitrequest,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic              resetlatch
);

   localparam int unsigned Depth = 1 << ADDR_W;

   typedef enum logic [1:0] {StIdle, StJrd, StJwr, StCrd} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
   logic [31:0]         mon_d_q, mon_d_d;
   logic                ready_q, ready_d;
   logic                error_q, error_d;
   logic                rlatch_q, rlatch_d;
   logic [31:0]         cpu_rdata_q, cpu_rdata_d;

   logic [31:0]         mem [Depth];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [31:0]         mem_wdata;
   logic                strobe;

   assign strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

   always_comb begin
      state_d     = state_q;
      mon_a_d     = mon_a_q;
      mon_d_d     = mon_d_q;
      ready_d     = ready_q;
      error_d     = error_q;
      rlatch_d    = rlatch_q;
      cpu_rdata_d = cpu_rdata_q;
      mem_we      = 1'b0;
      mem_waddr   = mon_a_q;
      mem_wdata   = mon_d_q;
      case (state_q)
         StIdle: begin
            if (take_action_ocimem_b) begin
               mon_d_d = jdo[34:3];
               ready_d = 1'b0;
               state_d = StJwr;
            end else if (take_action_ocimem_a) begin
               mon_a_d = jdo[ADDR_W+25:26];
               if (jdo[24]) rlatch_d = 1'b0;
               if (jdo[23]) error_d = 1'b0;
               if (jdo[25]) begin
                  ready_d = 1'b0;
                  state_d = StJrd;
               end else begin
                  // Address-only load completes immediately
                  ready_d = 1'b1;
               end
            end else if (take_no_action_ocimem_a) begin
               ready_d = 1'b0;
               state_d = StJrd;
`ifdef LAB3_OCIMEM_CPU_PORT_EN
            end else if (cpu_read) begin
               cpu_rdata_d = mem[cpu_address];
               state_d     = StCrd;
            end else if (cpu_write) begin
               mem_we    = 1'b1;
               mem_waddr = cpu_address;
               mem_wdata = cpu_writedata;
`endif
            end
         end
         StJrd: begin
            mon_d_d = mem[mon_a_q];
            mon_a_d = mon_a_q + ADDR_W'(1);
            ready_d = 1'b1;
            state_d = StIdle;
         end
         StJwr: begin
            mem_we  = 1'b1;
            mon_a_d = mon_a_q + ADDR_W'(1);
            ready_d = 1'b1;
            state_d = StIdle;
         end
         StCrd: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Strobes arriving while busy are dropped; setting takes precedence over clearing
      if (state_q != StIdle && strobe) error_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         mon_a_q     <= '0;
         mon_d_q     <= '0;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
         rlatch_q    <= 1'b1;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mon_a_q     <= mon_a_d;
         mon_d_q     <= mon_d_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
         rlatch_q    <= rlatch_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   // RAM contents survive reset; reset forces the state out of JWR so no write commits
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign MonDReg       = mon_d_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;
   assign resetlatch    = rlatch_q;

`ifdef LAB3_OCIMEM_CPU_PORT_EN
   assign cpu_readdata    = cpu_rdata_q;
   assign cpu_waitrequest = (state_q == StCrd) ? 1'b0
                          : ((state_q != StIdle) | strobe | cpu_read);
   logic unused_jdo;
   assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
`else
   assign cpu_readdata    = '0;
   assign cpu_waitrequest = 1'b0;
   logic unused_cpu;
   assign unused_cpu = ^{cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_rdata_q,
                         jdo[37:35], jdo[2:0]};
`endif

endmodule

// File: doc/lab3_cpu_ocimem_monitor.md
# lab3_cpu_ocimem_monitor

Sysclk-domain consumer of the JTAG debug module's decoded strobes and `jdo` payload. It owns the on-chip debug monitor RAM, the monitor address/data registers and the `monitor_ready`/`monitor_error`/`resetlatch` status bits. Those bits and `MonDReg` feed back into the debug module's TCK-side capture path. An optional CPU-side Avalon-MM slave port gives the Nios II core access to the same RAM, with JTAG taking priority.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width; the RAM depth is 2^ADDR_W × 32 bits.

Ports:
- `clk`, in, 1: system clock; single clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `jdo`, in, 38: JTAG payload, valid in the cycle a strobe is high.
- `take_action_ocimem_a`, in, 1: address/control load strobe.
- `take_action_ocimem_b`, in, 1: data write strobe.
- `take_no_action_ocimem_a`, in, 1: read-step strobe.
- `cpu_address`, in, ADDR_W: CPU word address.
- `cpu_read`, in, 1: CPU read request.
- `cpu_write`, in, 1: CPU write request.
- `cpu_writedata`, in, 32: CPU write data.
- `cpu_readdata`, out, 32: CPU read data.
- `cpu_waitrequest`, out, 1: CPU stall.
- `MonDReg`, out, 32: monitor data register.
- `monitor_ready`, out, 1: the last JTAG operation has completed.
- `monitor_error`, out, 1: a strobe was dropped because the block was busy.
- `resetlatch`, out, 1: a reset has occurred since the bit was last cleared.

## Operation
Field map for `take_action_ocimem_a` (only this strobe decodes these fields):
- `jdo[ADDR_W+25:26]` loads `MonAReg`.
- `jdo[25]` requests a read at the new address.
- `jdo[24]` clears `resetlatch`.
- `jdo[23]` clears `monitor_error`.

Strobe behaviour:
- `take_action_ocimem_b`: `MonDReg` ← `jdo[34:3]`, then the RAM is written at `MonAReg` and `MonAReg` increments.
- `take_no_action_ocimem_a`: the RAM is read at `MonAReg` into `MonDReg`, then `MonAReg` increments.
- `MonAReg` wraps from 2^ADDR_W−1 to 0.

FSM states: `IDLE`, `JRD` (RAM address presented), `JWR` (RAM write), `CRD` (CPU read data phase).
- `IDLE` to `JRD`: on `take_no_action_ocimem_a`, or on `take_action_ocimem_a` with `jdo[25]`=1.
- `JRD` to `IDLE`: `MonDReg` captures the RAM output and `monitor_ready` is set.
- `IDLE` to `JWR` on `take_action_ocimem_b`; then `JWR` to `IDLE` with `monitor_ready` set.
- `IDLE` to `CRD` on `cpu_read`; `CRD` to `IDLE` with `cpu_waitrequest`=0 and `cpu_readdata` valid in `CRD`.
- `take_action_ocimem_a` without `jdo[25]` stays in `IDLE` and sets `monitor_ready` next cycle.

Handshake and priority:
- `monitor_ready` clears in the cycle after any accepted JTAG strobe.
- Any strobe arriving while the state is not `IDLE` is dropped and sets `monitor_error`.
- Simultaneous set and clear of `monitor_error`: set wins.
- Multiple strobes in one cycle: priority is `ocimem_b` > `ocimem_a` > `no_action_ocimem_a`; the others are dropped without an error.
- A JTAG strobe and a CPU request in the same `IDLE` cycle: JTAG wins and `cpu_waitrequest`=1.
- `cpu_waitrequest` is combinational: 1 when the state is not `IDLE` or a JTAG strobe is present. In `CRD` it is 0.
- A CPU write is accepted in the `IDLE` cycle with `cpu_waitrequest`=0. The RAM is written at that edge and the state stays `IDLE`.
- Simultaneous `cpu_read` and `cpu_write` are treated as a read.

Reset:
- `MonAReg`=0, `MonDReg`=0, `monitor_ready`=0, `monitor_error`=0, `resetlatch`=1, `cpu_readdata`=0, state `IDLE`.
- RAM contents are not reset.
- Reset mid-operation aborts the operation. A pending write is not committed.

## Timing
- JTAG read, strobe at edge N: RAM address presented in cycle N+1 (`JRD`). `MonDReg` is valid and `monitor_ready`=1 from edge N+2.
- JTAG write, strobe at edge N: `MonDReg` is loaded at edge N+1, and the RAM write commits and `monitor_ready`=1 at edge N+2.
- CPU read: 2 cycles. Cycle 1 has `cpu_waitrequest`=1; cycle 2 has data valid and `cpu_waitrequest`=0.
- CPU write: 1 cycle when uncontended.
- RAM: synchronous read and write, read-during-write returns old data. The FSM never issues a read and a write in the same cycle.

## Configuration
- `LAB3_OCIMEM_CPU_PORT_EN` defined: the CPU port and the `CRD` state are compiled in.
- Undefined:
  - The CPU inputs are ignored.
  - `cpu_readdata`=0 and `cpu_waitrequest`=0 constantly.
  - The CPU cannot alter the RAM.

## Test plan
- Reset, then: `resetlatch`=1, `monitor_ready`=0, `MonDReg`=0. Then `ocimem_a` with `jdo[24]`=1 gives `resetlatch`=0 and `monitor_ready`=1 on the next cycle.
- `ocimem_a` with address 0x10, then `ocimem_b` with data 0xDEADBEEF, then `ocimem_a` with address 0x10 and `jdo[25]`=1: `MonDReg`=0xDEADBEEF two cycles later, and `MonAReg`=0x11.
- `ocimem_a` with address 0xFF, then two `no_action` reads: the address wraps 0xFF→0x00→0x01, and each read's data matches the RAM at that address.
- Strobe issued one cycle after a read strobe: it is dropped, `monitor_error`=1. A following `ocimem_a` with `jdo[23]`=1 clears `monitor_error`.
- CPU write 0x12345678 to 0x20, then JTAG read of 0x20: `MonDReg`=0x12345678. CPU read of 0x20 coincident with a JTAG strobe: `cpu_waitrequest` is held until the JTAG operation completes, then data returns 2 cycles later.
- `LAB3_OCIMEM_CPU_PORT_EN` undefined: a CPU write to 0x20 leaves the RAM unchanged, and `cpu_waitrequest`=0 throughout.
